// File: rtl/wired_rob_ring_if.sv
// Bus bundle between dispatch, CDB, operand-read, commit and the wired_rob_ring reorder buffer.
// slave is the ROB side; master is the pipeline (or bench) side.
interface wired_rob_ring_if #(
    parameter int DEPTH      = 16,
    parameter int DISPATCH_W = 2,
    parameter int RETIRE_W   = 2,
    parameter int CDB_W      = 2,
    parameter int RD_W       = 4,
    parameter int STATIC_W   = 64,
    parameter int DATA_W     = 32
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic                                 flush_i;
    logic [DISPATCH_W-1:0]                alloc_valid_i;
    logic [DISPATCH_W-1:0][STATIC_W-1:0]  alloc_static_i;
    logic                                 alloc_ready_o;
    logic [DISPATCH_W-1:0][IW-1:0]        alloc_rid_o;
    logic [CDB_W-1:0]                     cdb_valid_i;
    logic [CDB_W-1:0][IW-1:0]             cdb_rid_i;
    logic [CDB_W-1:0][DATA_W-1:0]         cdb_data_i;
    logic [CDB_W-1:0]                     cdb_excp_i;
    logic [RD_W-1:0][IW-1:0]              op_rid_i;
    logic [RD_W-1:0]                      op_ready_o;
    logic [RD_W-1:0][DATA_W-1:0]          op_data_o;
    logic [RETIRE_W-1:0]                  head_valid_o;
    logic [RETIRE_W-1:0][IW-1:0]          head_rid_o;
    logic [RETIRE_W-1:0][STATIC_W-1:0]    head_static_o;
    logic [RETIRE_W-1:0][DATA_W-1:0]      head_data_o;
    logic [RETIRE_W-1:0]                  head_excp_o;
    logic [RETIRE_W-1:0]                  retire_i;
    logic [PW-1:0]                        count_o;

    modport slave (
        input  flush_i, alloc_valid_i, alloc_static_i,
        input  cdb_valid_i, cdb_rid_i, cdb_data_i, cdb_excp_i,
        input  op_rid_i, retire_i,
        output alloc_ready_o, alloc_rid_o, op_ready_o, op_data_o,
        output head_valid_o, head_rid_o, head_static_o, head_data_o, head_excp_o,
        output count_o
    );

    modport master (
        output flush_i, alloc_valid_i, alloc_static_i,
        output cdb_valid_i, cdb_rid_i, cdb_data_i, cdb_excp_i,
        output op_rid_i, retire_i,
        input  alloc_ready_o, alloc_rid_o, op_ready_o, op_data_o,
        input  head_valid_o, head_rid_o, head_static_o, head_data_o, head_excp_o,
        input  count_o
    );
endinterface

// File: rtl/wired_rob_ring.sv
// In-order reorder buffer ring: compacted multi-lane allocate, CDB completion, exception-gated retire, flush.
// Define WIRED_ROB_CDB_BYPASS_EN to forward same-cycle CDB writes to operand reads and head lanes.
module wired_rob_ring #(
    parameter int DEPTH      = 16,
    parameter int DISPATCH_W = 2,
    parameter int RETIRE_W   = 2,
    parameter int CDB_W      = 2,
    parameter int RD_W       = 4,
    parameter int STATIC_W   = 64,
    parameter int DATA_W     = 32
) (
    input logic             clk,
    input logic             rst,
    wired_rob_ring_if.slave rob
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);
    localparam logic [PW:0] DISP_L  = (PW+1)'(DISPATCH_W);

    logic [PW-1:0]       head_q, tail_q, count;
    logic [DEPTH-1:0]    done_q, excp_q;
    logic [STATIC_W-1:0] static_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic                          alloc_ready, alloc_fire;
    logic [PW-1:0]                 alloc_cnt, retire_cnt;
    logic [DISPATCH_W-1:0][IW-1:0] alloc_rid;
    logic [CDB_W-1:0]              cdb_hit;
    logic [DEPTH-1:0]              done_eff, excp_eff;
    logic [DATA_W-1:0]             data_eff [DEPTH];
    logic [RETIRE_W-1:0]           head_valid, head_excp;

    // Occupied means the rid lies in [head, tail) modulo the ring.
    function automatic logic occupied(input logic [IW-1:0] rid,
                                      input logic [PW-1:0] head,
                                      input logic [PW-1:0] cnt);
        logic [IW-1:0] off;
        off = rid - head[IW-1:0];
        return {1'b0, off} < cnt;
    endfunction

    assign count       = tail_q - head_q;
    assign alloc_ready = (DEPTH_L - {1'b0, count}) >= DISP_L;
    assign alloc_fire  = alloc_ready && (|rob.alloc_valid_i);

    // NOTE: blocking temporaries inside always_comb are assigned before any use, so no latch is inferred.
    always_comb begin
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            alloc_rid[i] = tail_q[IW-1:0] + acc[IW-1:0];
            if (rob.alloc_valid_i[i]) acc = acc + PW'(1);
        end
        alloc_cnt = acc;
    end

    always_comb begin
        for (int c = 0; c < CDB_W; c++)
            cdb_hit[c] = rob.cdb_valid_i[c] && occupied(rob.cdb_rid_i[c], head_q, count);
    end

`ifdef WIRED_ROB_CDB_BYPASS_EN
    always_comb begin
        done_eff = done_q;
        excp_eff = excp_q;
        data_eff = data_mem;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_hit[c]) begin
                done_eff[rob.cdb_rid_i[c]] = 1'b1;
                excp_eff[rob.cdb_rid_i[c]] = rob.cdb_excp_i[c];
                data_eff[rob.cdb_rid_i[c]] = rob.cdb_data_i[c];
            end
        end
    end
`else
    always_comb begin
        done_eff = done_q;
        excp_eff = excp_q;
        data_eff = data_mem;
    end
`endif

    // A lane may retire only if every older lane retires and none of them excepts.
    always_comb begin
        logic          chain;
        logic [IW-1:0] rid;
        chain = 1'b1;
        rid   = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            rid                  = head_q[IW-1:0] + IW'(i);
            rob.head_rid_o[i]    = rid;
            rob.head_static_o[i] = static_mem[rid];
            rob.head_data_o[i]   = data_eff[rid];
            head_excp[i]         = excp_eff[rid];
            head_valid[i]        = chain && (PW'(i) < count) && done_eff[rid];
            chain                = head_valid[i] && !head_excp[i];
        end
    end

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < RETIRE_W; i++)
            if (rob.retire_i[i] && head_valid[i]) retire_cnt = retire_cnt + PW'(1);
    end

    always_comb begin
        for (int r = 0; r < RD_W; r++) begin
            rob.op_ready_o[r] = done_eff[rob.op_rid_i[r]];
            rob.op_data_o[r]  = data_eff[rob.op_rid_i[r]];
        end
    end

    assign rob.alloc_ready_o = alloc_ready;
    assign rob.alloc_rid_o   = alloc_rid;
    assign rob.head_valid_o  = head_valid;
    assign rob.head_excp_o   = head_excp;
    assign rob.count_o       = count;

    // NOTE: non-blocking updates; a later loop iteration overrides an earlier one, so the highest CDB channel wins.
    always_ff @(posedge clk) begin
        if (rst || rob.flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
            excp_q <= '0;
        end else begin
            head_q <= head_q + retire_cnt;
            if (alloc_fire) tail_q <= tail_q + alloc_cnt;
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (alloc_fire && rob.alloc_valid_i[i]) begin
                    done_q[alloc_rid[i]] <= 1'b0;
                    excp_q[alloc_rid[i]] <= 1'b0;
                end
            end
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_hit[c]) begin
                    done_q[rob.cdb_rid_i[c]] <= 1'b1;
                    excp_q[rob.cdb_rid_i[c]] <= rob.cdb_excp_i[c];
                end
            end
        end
    end

    // NOTE: payload RAMs carry no reset; done bits gate every consumer, so stale contents are harmless.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISPATCH_W; i++)
            if (alloc_fire && rob.alloc_valid_i[i]) static_mem[alloc_rid[i]] <= rob.alloc_static_i[i];
        for (int c = 0; c < CDB_W; c++)
            if (cdb_hit[c]) data_mem[rob.cdb_rid_i[c]] <= rob.cdb_data_i[c];
    end
endmodule

// File: tb/tb_wired_rob_ring.sv
// Directed, table-driven bench for wired_rob_ring (DEPTH=16, 2-wide allocate/retire/CDB, 4 read ports).
module tb_wired_rob_ring;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wired_rob_ring_if bus ();
    wired_rob_ring dut (.clk(clk), .rst(rst), .rob(bus));

    int checks = 0;
    int errors = 0;

`ifdef WIRED_ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [1:0]  alloc, retire, cdb_v, cdb_x;
        logic [3:0]  r0, r1;
        logic        flush;
        logic [3:0]  e_rid0, e_rid1, e_hrid0;
        logic [4:0]  e_count;
        logic        e_ready;
        logic [1:0]  e_hv, e_hx;
        logic [31:0] e_hd0;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cdb_word(input int ch, input int rid);
        return 32'hD000_0000 | 32'(ch << 16) | 32'(rid);
    endfunction

    function automatic logic [63:0] stat_word(input logic [3:0] rid);
        return {32'hC0DE_0000, 28'h0, rid};
    endfunction

    // Fields: alloc, retire, cdb_v, r0, r1, cdb_x, flush | rid0, rid1 (pre-edge) | count, ready, hv, hx, hrid0, hd0 (post-edge)
    function automatic vec_t mk(input int alloc, input int retire, input int cdb_v, input int r0,
                                input int r1, input int cdb_x, input int flush, input int e_rid0,
                                input int e_rid1, input int e_count, input int e_ready, input int e_hv,
                                input int e_hx, input int e_hrid0, input logic [31:0] e_hd0);
        vec_t v;
        v.alloc = 2'(alloc);   v.retire = 2'(retire); v.cdb_v = 2'(cdb_v); v.cdb_x = 2'(cdb_x);
        v.r0 = 4'(r0);         v.r1 = 4'(r1);         v.flush = 1'(flush);
        v.e_rid0 = 4'(e_rid0); v.e_rid1 = 4'(e_rid1); v.e_hrid0 = 4'(e_hrid0);
        v.e_count = 5'(e_count); v.e_ready = 1'(e_ready);
        v.e_hv = 2'(e_hv);     v.e_hx = 2'(e_hx);     v.e_hd0 = e_hd0;
        return v;
    endfunction

    task automatic idle();
        bus.flush_i        = 1'b0;
        bus.alloc_valid_i  = '0;
        bus.alloc_static_i = '0;
        bus.cdb_valid_i    = '0;
        bus.cdb_rid_i      = '0;
        bus.cdb_data_i     = '0;
        bus.cdb_excp_i     = '0;
        bus.retire_i       = '0;
    endtask

    // Clock edge, then release inputs so post-edge checks see registered state only.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        // Lane bit order: 3 = both lanes, 1 = lane0 only, 2 = lane1 only.
        vecs[0]  = mk(3, 0, 0,  0, 0, 0, 0,  0,  1,  2, 1, 0, 0, 0, 32'h0);
        vecs[1]  = mk(3, 0, 1,  1, 0, 0, 0,  2,  3,  4, 1, 0, 0, 0, 32'h0);
        vecs[2]  = mk(1, 0, 0,  0, 0, 0, 0,  4,  5,  5, 1, 0, 0, 0, 32'h0);
        vecs[3]  = mk(2, 0, 1,  0, 0, 0, 0,  5,  5,  6, 1, 3, 0, 0, cdb_word(0, 0));
        vecs[4]  = mk(0, 3, 0,  0, 0, 0, 0,  6,  6,  4, 1, 0, 0, 2, 32'h0);
        vecs[5]  = mk(0, 0, 3,  3, 2, 2, 0,  6,  6,  4, 1, 1, 1, 2, cdb_word(1, 2));
        vecs[6]  = mk(0, 1, 0,  0, 0, 0, 0,  6,  6,  3, 1, 1, 0, 3, cdb_word(0, 3));
        vecs[7]  = mk(0, 0, 3,  4, 4, 1, 0,  6,  6,  3, 1, 3, 0, 3, cdb_word(0, 3));
        vecs[8]  = mk(0, 3, 0,  0, 0, 0, 0,  6,  6,  1, 1, 0, 0, 5, 32'h0);
        vecs[9]  = mk(3, 0, 0,  0, 0, 0, 0,  6,  7,  3, 1, 0, 0, 5, 32'h0);
        vecs[10] = mk(3, 0, 0,  0, 0, 0, 0,  8,  9,  5, 1, 0, 0, 5, 32'h0);
        vecs[11] = mk(3, 0, 0,  0, 0, 0, 0, 10, 11,  7, 1, 0, 0, 5, 32'h0);
        vecs[12] = mk(3, 0, 0,  0, 0, 0, 0, 12, 13,  9, 1, 0, 0, 5, 32'h0);
        vecs[13] = mk(3, 0, 0,  0, 0, 0, 0, 14, 15, 11, 1, 0, 0, 5, 32'h0);
        vecs[14] = mk(3, 0, 0,  0, 0, 0, 0,  0,  1, 13, 1, 0, 0, 5, 32'h0);
        vecs[15] = mk(3, 0, 0,  0, 0, 0, 0,  2,  3, 15, 0, 0, 0, 5, 32'h0);
        vecs[16] = mk(3, 0, 1,  5, 0, 0, 0,  4,  5, 15, 0, 1, 0, 5, cdb_word(0, 5));
        vecs[17] = mk(3, 1, 0,  0, 0, 0, 0,  4,  5, 14, 1, 0, 0, 6, 32'h0);
        vecs[18] = mk(3, 0, 0,  0, 0, 0, 0,  4,  5, 16, 0, 0, 0, 6, 32'h0);
        vecs[19] = mk(0, 0, 3, 10, 6, 0, 0,  6,  6, 16, 0, 1, 0, 6, cdb_word(1, 6));
        vecs[20] = mk(0, 1, 1,  7, 0, 0, 0,  6,  6, 15, 0, 1, 0, 7, cdb_word(0, 7));
        vecs[21] = mk(0, 0, 1,  8, 0, 0, 0,  6,  6, 15, 0, 3, 0, 7, cdb_word(0, 7));
        vecs[22] = mk(0, 3, 1,  9, 0, 0, 0,  6,  6, 13, 1, 3, 0, 9, cdb_word(0, 9));
        vecs[23] = mk(3, 3, 1, 11, 0, 0, 1,  6,  7,  0, 1, 0, 0, 0, 32'h0);
        vecs[24] = mk(3, 0, 0,  0, 0, 0, 0,  0,  1,  2, 1, 0, 0, 0, 32'h0);

        rst = 1'b1;
        idle();
        bus.op_rid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset count", 64'(bus.count_o), 64'd0);
        check("reset alloc_ready", 64'(bus.alloc_ready_o), 64'd1);
        check("reset head_valid", 64'(bus.head_valid_o), 64'd0);
        check("reset op_ready", 64'(bus.op_ready_o), 64'd0);

        for (int i = 0; i < NV; i++) begin
            bus.alloc_valid_i     = vecs[i].alloc;
            bus.retire_i          = vecs[i].retire;
            bus.flush_i           = vecs[i].flush;
            bus.alloc_static_i[0] = stat_word(vecs[i].e_rid0);
            bus.alloc_static_i[1] = stat_word(vecs[i].e_rid1);
            bus.cdb_valid_i       = vecs[i].cdb_v;
            bus.cdb_rid_i[0]      = vecs[i].r0;
            bus.cdb_rid_i[1]      = vecs[i].r1;
            bus.cdb_excp_i        = vecs[i].cdb_x;
            bus.cdb_data_i[0]     = cdb_word(0, int'(vecs[i].r0));
            bus.cdb_data_i[1]     = cdb_word(1, int'(vecs[i].r1));
            #1;
            check($sformatf("v%0d alloc_rid0", i), 64'(bus.alloc_rid_o[0]), 64'(vecs[i].e_rid0));
            check($sformatf("v%0d alloc_rid1", i), 64'(bus.alloc_rid_o[1]), 64'(vecs[i].e_rid1));
            tick();
            check($sformatf("v%0d count", i), 64'(bus.count_o), 64'(vecs[i].e_count));
            check($sformatf("v%0d alloc_ready", i), 64'(bus.alloc_ready_o), 64'(vecs[i].e_ready));
            check($sformatf("v%0d head_valid", i), 64'(bus.head_valid_o), 64'(vecs[i].e_hv));
            check($sformatf("v%0d head_excp", i), 64'(bus.head_excp_o), 64'(vecs[i].e_hx));
            check($sformatf("v%0d head_rid0", i), 64'(bus.head_rid_o[0]), 64'(vecs[i].e_hrid0));
            if (vecs[i].e_count != 5'd0)
                check($sformatf("v%0d head_static0", i), bus.head_static_o[0], stat_word(vecs[i].e_hrid0));
            if (vecs[i].e_hv[0])
                check($sformatf("v%0d head_data0", i), 64'(bus.head_data_o[0]), 64'(vecs[i].e_hd0));
        end

        // Allocate rids 2,3 behind the two live entries.
        bus.alloc_valid_i     = 2'b11;
        bus.alloc_static_i[0] = stat_word(4'd2);
        bus.alloc_static_i[1] = stat_word(4'd3);
        #1;
        check("seq alloc_rid0", 64'(bus.alloc_rid_o[0]), 64'd2);
        tick();
        check("seq count", 64'(bus.count_o), 64'd4);

        // Same-cycle CDB to rid 3 (occupied) and rid 12 (unoccupied); rid 9 was completed before the flush.
        bus.op_rid_i[0]   = 4'd3;
        bus.op_rid_i[1]   = 4'd12;
        bus.op_rid_i[2]   = 4'd0;
        bus.op_rid_i[3]   = 4'd9;
        bus.cdb_valid_i   = 2'b11;
        bus.cdb_rid_i[0]  = 4'd3;
        bus.cdb_data_i[0] = 32'h0000_DEAD;
        bus.cdb_rid_i[1]  = 4'd12;
        bus.cdb_data_i[1] = 32'h0000_1234;
        #1;
        check("bypass op_ready3", 64'(bus.op_ready_o[0]), 64'(BYP));
        check("bypass op_data3", 64'(bus.op_ready_o[0] ? bus.op_data_o[0] : 32'h0),
              64'(BYP ? 32'h0000_DEAD : 32'h0));
        check("same-cycle op_ready12", 64'(bus.op_ready_o[1]), 64'd0);
        check("flushed op_ready9", 64'(bus.op_ready_o[3]), 64'd0);
        tick();
        check("op_ready3", 64'(bus.op_ready_o[0]), 64'd1);
        check("op_data3", 64'(bus.op_data_o[0]), 64'h0000_DEAD);
        check("unoccupied op_ready12", 64'(bus.op_ready_o[1]), 64'd0);
        check("op_ready0", 64'(bus.op_ready_o[2]), 64'd0);

        // Reset in the middle of operation discards everything.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midreset count", 64'(bus.count_o), 64'd0);
        check("midreset alloc_ready", 64'(bus.alloc_ready_o), 64'd1);
        check("midreset head_valid", 64'(bus.head_valid_o), 64'd0);
        check("midreset op_ready3", 64'(bus.op_ready_o[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wired_rob_ring.md
# wired_rob_ring

Parametrised in-order reorder buffer for the Wired out-of-order backend. It sits between dispatch (P stage) and commit (C stage). It allocates up to DISPATCH_W entries per cycle at the tail and accepts up to CDB_W completion writes per cycle. It serves RD_W operand-read ports and presents up to RETIRE_W completed entries in order at the head. Unlike the fixed 2-wide generation, it owns its head/tail pointers, occupancy and backpressure, supports exception-gated retirement, and supports a full flush.

## Interface
- DEPTH, 16: entry count; power of two, ≥ max(DISPATCH_W, RETIRE_W).
- DISPATCH_W, 2: allocate lanes per cycle.
- RETIRE_W, 2: retire lanes per cycle.
- CDB_W, 2: completion write channels.
- RD_W, 4: operand-read ports.
- STATIC_W, 64: static payload bits written at allocation.
- DATA_W, 32: result bits written by the CDB.
- Derived: IW = $clog2(DEPTH) for the rid width; PW = IW+1 for pointers and count.
- clk  in  1  clock; everything is posedge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all entries.
- alloc_valid_i  in  DISPATCH_W  per-lane allocate request.
- alloc_static_i  in  DISPATCH_W×STATIC_W  static payload.
- alloc_ready_o  out  1  free entries ≥ DISPATCH_W.
- alloc_rid_o  out  DISPATCH_W×IW  rid assigned to each lane.
- cdb_valid_i  in  CDB_W  completion write enable.
- cdb_rid_i  in  CDB_W×IW  target rid.
- cdb_data_i  in  CDB_W×DATA_W  result.
- cdb_excp_i  in  CDB_W  completion carries an exception.
- op_rid_i  in  RD_W×IW  operand lookup rid.
- op_ready_o  out  RD_W  entry is completed.
- op_data_o  out  RD_W×DATA_W  entry result.
- head_valid_o  out  RETIRE_W  lane may retire.
- head_rid_o  out  RETIRE_W×IW  rid at each head lane.
- head_static_o  out  RETIRE_W×STATIC_W  static payload at each head lane.
- head_data_o  out  RETIRE_W×DATA_W  result at each head lane.
- head_excp_o  out  RETIRE_W  exception flag at each head lane.
- retire_i  in  RETIRE_W  retire request; must be a prefix of head_valid_o.
- count_o  out  PW  occupied entries.

## Operation
- State: head_q and tail_q (PW bits, MSB is the wrap bit), count_q = tail_q − head_q, a per-entry done bit, an excp bit, static RAM and data RAM.
- Allocation is compacted. Lane i takes rid tail_q + popcount(alloc_valid_i[i-1:0]) mod DEPTH. alloc_rid_o is driven regardless of alloc_valid_i.
- Allocation is all-or-nothing. Any alloc_valid_i while alloc_ready_o is low is a protocol error and is ignored. alloc_ready_o = (DEPTH − count_q) ≥ DISPATCH_W, from registered count only.
- Allocation writes the static payload and clears done and excp for each allocated entry. tail_q advances by popcount.
- A CDB write sets done, writes data and writes excp at its rid.
  - If two channels hit the same rid, the higher channel index wins.
  - A CDB write to a rid allocated in the same cycle is illegal.
  - A CDB write to an unoccupied rid is ignored (range check against head_q/tail_q).
- Head lane i presents rid head_q+i.
- head_valid_o[i] requires all of:
  - i < count_q;
  - the entry's done bit is set;
  - head_valid_o[i−1] is high;
  - head_excp_o[i−1] is low.
- An excepting entry can therefore retire only as the last valid lane.
- Retirement advances head_q by popcount(retire_i). Retire and allocate in the same cycle are both applied, with count_q updated by the net amount.
- flush_i has priority over alloc, CDB and retire in the same cycle. Next cycle: head_q = tail_q = 0 and all done bits are 0. RAM contents are don't-care.

## Timing
- Reset (rst high at a posedge), next cycle:
  - head_q = tail_q = count_o = 0;
  - all done and excp bits = 0;
  - head_valid_o = 0, op_ready_o = 0, alloc_ready_o = 1.
- Reset mid-operation discards everything.
- Operand reads and head outputs are combinational from registered state, with 0-cycle read latency.
- Alloc, CDB, retire and flush effects become visible one cycle later.
- A retire in cycle t frees slots for allocation in cycle t+1, not cycle t.
- Wrap-around: a full ROB has count_o = DEPTH, with head and tail indices equal and wrap bits differing.

## Configuration
- WIRED_ROB_CDB_BYPASS_EN defined:
  - op_ready_o and op_data_o forward a same-cycle matching cdb write (highest channel wins);
  - head lanes also see same-cycle completions.
- Not defined: completions are visible one cycle after the CDB write.

## Test plan
- Reset: after rst, count_o=0, alloc_ready_o=1, head_valid_o=0; then alloc 2'b11 -> alloc_rid_o={1,0}, count_o=2 next cycle.
- Compaction: alloc_valid_i=2'b10 with tail 5 -> lane1 rid 5, tail 6.
- Full: DEPTH=16, fill to 15 -> alloc_ready_o=0. Retire 1 -> alloc_ready_o=1 the following cycle; wrap rid 15→0 is correct.
- Out-of-order completion: CDB writes rid 1 before rid 0 -> head_valid_o stays 00 until rid 0 completes, then 11.
- Exception: rid 0 done with excp=1, rid 1 done -> head_valid_o=01, head_excp_o[0]=1.
- Flush with simultaneous alloc, CDB and retire -> next cycle count_o=0, head_valid_o=0. With WIRED_ROB_CDB_BYPASS_EN, an op read of rid 3 during a CDB write of 0xDEAD returns ready=1, data=0xDEAD that same cycle; without the macro, ready=0 that cycle.
